// File: rtl/cpu_controller_pkg.sv
// Shared types for the cache controller: line coherence states and snoop-bus command encodings.
package cache_states;
    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } State_t;
endpackage

package commands;
    typedef enum logic [1:0] {
        BUS_READ           = 2'd0,
        BUS_READ_EXCLUSIVE = 2'd1,
        BUS_INVALIDATE     = 2'd2,
        BUS_WRITE_BACK     = 2'd3
    } BusCommand_t;
endpackage

// File: rtl/cpu_controller_bus_handshake.sv
// Request/grant/ack handshake for one bus transaction; an ack only counts once a grant has been seen.
module bus_handshake (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic bus_grant_i,
    input  logic bus_ack_i,
    output logic bus_request_o,
    output logic ack_o
);
    logic granted_q;
    logic granted_d;

    assign bus_request_o = active_i;
    assign ack_o         = active_i && bus_ack_i && granted_q;

    // Grant is remembered so a grant that drops before the ack keeps the transaction alive.
    always_comb begin
        granted_d = active_i && !ack_o && (granted_q || bus_grant_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            granted_q <= 1'b0;
        end else begin
            granted_q <= granted_d;
        end
    end
endmodule

// File: rtl/cpu_controller.sv
// Cache controller: looks up the line, runs any bus transactions the coherence protocol needs,
// then writes the new line state and releases the CPU.
module cpu_controller
    import cache_states::*;
#(
    parameter type STATE_TYPE    = cache_states::State_t,
    parameter int  ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpuRead,
    input  logic                     cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
    output logic                     cpuWaitRequest,
    input  logic                     tagHit,
    input  STATE_TYPE                lineState,
    input  logic [ADDRESS_WIDTH-1:0] victimAddress,
    output logic                     stateWrite,
    output STATE_TYPE                stateWriteValue,
    output logic                     read,
    output logic                     write,
    output STATE_TYPE                stateOut,
    output STATE_TYPE                writeBackState,
    input  STATE_TYPE                stateIn,
    input  logic                     writeBackRequired,
    input  logic                     invalidateRequired,
    input  logic                     readExclusiveRequired,
    output logic                     busRequest,
    input  logic                     busGrant,
    output logic [1:0]               busCommand,
    output logic [ADDRESS_WIDTH-1:0] busAddress,
    input  logic                     busAck
);
    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITE_BACK, READ_EXCLUSIVE, INVALIDATE, BUS_READ, UPDATE, DONE
    } ctrl_state_t;

    localparam STATE_TYPE ST_INVALID = STATE_TYPE'(INVALID);

    ctrl_state_t              state_q, state_d;
    logic                     wr_q, wr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     wb_done_q, wb_done_d;
    logic                     in_bus;
    logic                     bus_ack_ok;

    assign stateOut       = tagHit ? lineState : ST_INVALID;
    assign writeBackState = tagHit ? ST_INVALID : lineState;

    assign cpuWaitRequest = (state_q != IDLE) && (state_q != DONE);
    assign read           = cpuWaitRequest && !wr_q;
    assign write          = cpuWaitRequest && wr_q;
    assign in_bus         = state_q inside {WRITE_BACK, READ_EXCLUSIVE, INVALIDATE, BUS_READ};

    bus_handshake u_bus (
        .clk_i        (clock),
        .rst_ni       (reset),
        .active_i     (in_bus),
        .bus_grant_i  (busGrant),
        .bus_ack_i    (busAck),
        .bus_request_o(busRequest),
        .ack_o        (bus_ack_ok)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            wb_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_done_q <= wb_done_d;
        end
        wr_q   <= wr_d;
        addr_q <= addr_d;
    end

    always_comb begin
        state_d         = state_q;
        wr_d            = wr_q;
        addr_d          = addr_q;
        wb_done_d       = wb_done_q;
        stateWrite      = 1'b0;
        stateWriteValue = ST_INVALID;
        busCommand      = 2'd0;
        busAddress      = '0;
        case (state_q)
            IDLE: begin
                if (cpuRead || cpuWrite) begin
                    wr_d      = cpuWrite;
                    addr_d    = cpuAddress;
                    wb_done_d = 1'b0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                // After a victim write-back the line is re-examined, but never written back twice.
                if (writeBackRequired && !wb_done_q)       state_d = WRITE_BACK;
                else if (readExclusiveRequired)            state_d = READ_EXCLUSIVE;
                else if (invalidateRequired)               state_d = INVALIDATE;
                else if (!wr_q && stateOut == ST_INVALID)  state_d = BUS_READ;
                else                                       state_d = UPDATE;
            end
            WRITE_BACK: begin
                busCommand = commands::BUS_WRITE_BACK;
                busAddress = victimAddress;
                if (bus_ack_ok) begin
                    stateWrite = 1'b1;
                    wb_done_d  = 1'b1;
                    state_d    = LOOKUP;
                end
            end
            READ_EXCLUSIVE: begin
                busCommand = commands::BUS_READ_EXCLUSIVE;
                busAddress = addr_q;
                if (bus_ack_ok) state_d = UPDATE;
            end
            INVALIDATE: begin
                busCommand = commands::BUS_INVALIDATE;
                busAddress = addr_q;
                if (bus_ack_ok) state_d = UPDATE;
            end
            BUS_READ: begin
                busCommand = commands::BUS_READ;
                busAddress = addr_q;
                if (bus_ack_ok) state_d = UPDATE;
            end
            UPDATE: begin
                stateWrite      = 1'b1;
                stateWriteValue = stateIn;
                state_d         = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed protocol scenarios plus randomized traffic against a transaction-level model.
module tb_cpu_controller;
    import cache_states::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpuRead, cpuWrite;
    logic [15:0] cpuAddress;
    logic        cpuWaitRequest;
    logic        tagHit;
    State_t      lineState;
    logic [15:0] victimAddress;
    logic        stateWrite;
    State_t      stateWriteValue;
    logic        read, write;
    State_t      stateOut, writeBackState, stateIn;
    logic        writeBackRequired, invalidateRequired, readExclusiveRequired;
    logic        busRequest, busGrant, busAck;
    logic [1:0]  busCommand;
    logic [15:0] busAddress;

    always #5 clock = ~clock;

    cpu_controller #(.STATE_TYPE(cache_states::State_t), .ADDRESS_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
        .cpuWaitRequest(cpuWaitRequest),
        .tagHit(tagHit), .lineState(lineState), .victimAddress(victimAddress),
        .stateWrite(stateWrite), .stateWriteValue(stateWriteValue),
        .read(read), .write(write), .stateOut(stateOut), .writeBackState(writeBackState),
        .stateIn(stateIn), .writeBackRequired(writeBackRequired),
        .invalidateRequired(invalidateRequired), .readExclusiveRequired(readExclusiveRequired),
        .busRequest(busRequest), .busGrant(busGrant), .busCommand(busCommand),
        .busAddress(busAddress), .busAck(busAck)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 lookup, 2 one bus operation (m_cmd), 3 update, 4 done.
    int          m_phase   = 0;
    logic        m_wr      = 1'b0;
    logic [15:0] m_addr    = '0;
    logic [1:0]  m_cmd     = 2'd0;
    bit          m_granted = 0;
    bit          m_wbdone  = 0;
    bit          chk_en    = 0;

    always @(posedge clock) begin
        if (!reset) begin
            m_phase   = 0;
            m_granted = 0;
            chk_en    = 1;
        end else begin
            case (m_phase)
                0: if (cpuRead || cpuWrite) begin
                    m_wr = cpuWrite; m_addr = cpuAddress; m_wbdone = 0; m_phase = 1;
                end
                1: begin
                    m_granted = 0;
                    m_phase   = 2;
                    if (writeBackRequired && !m_wbdone) m_cmd = 2'd3;
                    else if (readExclusiveRequired)    m_cmd = 2'd1;
                    else if (invalidateRequired)       m_cmd = 2'd2;
                    else if (!m_wr && (!tagHit || lineState == INVALID)) m_cmd = 2'd0;
                    else m_phase = 3;
                end
                2: begin
                    if (busAck && m_granted) begin
                        m_granted = 0;
                        if (m_cmd == 2'd3) begin m_wbdone = 1; m_phase = 1; end
                        else m_phase = 3;
                    end else if (busGrant) begin
                        m_granted = 1;
                    end
                end
                3: m_phase = 4;
                default: m_phase = 0;
            endcase
        end
    end

    bit     e_busy, e_ack;
    State_t e_so, e_wbs;

    always @(negedge clock) begin
        if (chk_en) begin
            e_busy = (m_phase >= 1) && (m_phase <= 3);
            e_ack  = (m_phase == 2) && busAck && m_granted;
            e_so   = tagHit ? lineState : INVALID;
            e_wbs  = tagHit ? INVALID : lineState;
            chk("cpuWaitRequest", 32'(cpuWaitRequest), 32'(e_busy));
            chk("read", 32'(read), 32'(e_busy && !m_wr));
            chk("write", 32'(write), 32'(e_busy && m_wr));
            chk("busRequest", 32'(busRequest), 32'(m_phase == 2));
            chk("busCommand", 32'(busCommand), (m_phase == 2) ? 32'(m_cmd) : 32'd0);
            chk("busAddress", 32'(busAddress),
                (m_phase == 2) ? ((m_cmd == 2'd3) ? 32'(victimAddress) : 32'(m_addr)) : 32'd0);
            chk("stateWrite", 32'(stateWrite), 32'((m_phase == 3) || (e_ack && m_cmd == 2'd3)));
            chk("stateWriteValue", 32'(stateWriteValue), (m_phase == 3) ? 32'(stateIn) : 32'(INVALID));
            chk("stateOut", 32'(stateOut), 32'(e_so));
            chk("writeBackState", 32'(writeBackState), 32'(e_wbs));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        reset = 1'b1; cpuRead = 1'b0; cpuWrite = 1'b0; cpuAddress = '0;
        tagHit = 1'b0; lineState = INVALID; victimAddress = '0; stateIn = INVALID;
        writeBackRequired = 1'b0; invalidateRequired = 1'b0; readExclusiveRequired = 1'b0;
        busGrant = 1'b0; busAck = 1'b0;
    endtask

    initial begin
        quiet();
        reset = 1'b0;
        step(); step();
        #3;
        chk("rst_wait", 32'(cpuWaitRequest), 32'd0);
        chk("rst_busreq", 32'(busRequest), 32'd0);
        chk("rst_swv", 32'(stateWriteValue), 32'(INVALID));
        reset = 1'b1;
        step();

        // Read hit on a SHARED line: write-back of state in cycle 3, release in cycle 4.
        cpuRead = 1'b1; cpuAddress = 16'h0040; tagHit = 1'b1; lineState = SHARED; stateIn = SHARED;
        #3 chk("hit_c1_wait", 32'(cpuWaitRequest), 32'd0);
        step(); cpuRead = 1'b0;
        #3 chk("hit_c2_wait", 32'(cpuWaitRequest), 32'd1);
        chk("hit_c2_read", 32'(read), 32'd1);
        chk("hit_c2_stateOut", 32'(stateOut), 32'(SHARED));
        step();
        #3 chk("hit_c3_sw", 32'(stateWrite), 32'd1);
        chk("hit_c3_swv", 32'(stateWriteValue), 32'(SHARED));
        step();
        #3 chk("hit_c4_wait", 32'(cpuWaitRequest), 32'd0);
        chk("hit_c4_sw", 32'(stateWrite), 32'd0);
        step();

        // Read miss with a stray ack before any grant.
        cpuRead = 1'b1; cpuAddress = 16'h0A50; tagHit = 1'b0; lineState = INVALID; stateIn = SHARED;
        step(); cpuRead = 1'b0;
        step();
        #3 chk("miss_req", 32'(busRequest), 32'd1);
        chk("miss_cmd", 32'(busCommand), 32'd0);
        chk("miss_addr", 32'(busAddress), 32'h0A50);
        step(); busAck = 1'b1;
        step(); busAck = 1'b0; busGrant = 1'b1;
        #3 chk("miss_stray_ack_ignored", 32'(busRequest), 32'd1);
        step(); busAck = 1'b1;
        #3 chk("miss_ack_req_held", 32'(busRequest), 32'd1);
        step(); busAck = 1'b0; busGrant = 1'b0;
        #3 chk("miss_req_dropped", 32'(busRequest), 32'd0);
        chk("miss_sw", 32'(stateWrite), 32'd1);
        chk("miss_swv", 32'(stateWriteValue), 32'(SHARED));
        step();
        #3 chk("miss_done_wait", 32'(cpuWaitRequest), 32'd0);
        step();

        // Write miss with dirty victim: write-back, then read-exclusive, final MODIFIED.
        cpuWrite = 1'b1; cpuAddress = 16'hABCD; victimAddress = 16'h1234; tagHit = 1'b0;
        lineState = MODIFIED; writeBackRequired = 1'b1; readExclusiveRequired = 1'b1; stateIn = MODIFIED;
        step(); cpuWrite = 1'b0;
        #3 chk("wb_wbstate", 32'(writeBackState), 32'(MODIFIED));
        step(); busGrant = 1'b1;
        #3 chk("wb_cmd", 32'(busCommand), 32'd3);
        chk("wb_addr", 32'(busAddress), 32'h1234);
        step(); busAck = 1'b1;
        #3 chk("wb_sw", 32'(stateWrite), 32'd1);
        chk("wb_swv", 32'(stateWriteValue), 32'(INVALID));
        step(); busAck = 1'b0; busGrant = 1'b0;
        #3 chk("wb_relookup_req", 32'(busRequest), 32'd0);
        step(); busGrant = 1'b1;
        #3 chk("rx_cmd", 32'(busCommand), 32'd1);
        chk("rx_addr", 32'(busAddress), 32'hABCD);
        step(); busAck = 1'b1;
        step(); busAck = 1'b0; busGrant = 1'b0;
        #3 chk("rx_swv", 32'(stateWriteValue), 32'(MODIFIED));
        step();
        #3 chk("rx_done_wait", 32'(cpuWaitRequest), 32'd0);
        step(); writeBackRequired = 1'b0; readExclusiveRequired = 1'b0;

        // Write hit SHARED needing invalidate; grant drops before the ack.
        cpuWrite = 1'b1; cpuAddress = 16'h0100; tagHit = 1'b1; lineState = SHARED;
        invalidateRequired = 1'b1; stateIn = MODIFIED;
        step(); cpuWrite = 1'b0;
        step(); busGrant = 1'b1;
        #3 chk("inv_cmd", 32'(busCommand), 32'd2);
        step(); busGrant = 1'b0;
        #3 chk("inv_req_held", 32'(busRequest), 32'd1);
        step(); busAck = 1'b1;
        step(); busAck = 1'b0;
        #3 chk("inv_sw", 32'(stateWrite), 32'd1);
        chk("inv_swv", 32'(stateWriteValue), 32'(MODIFIED));
        step(); step(); invalidateRequired = 1'b0;

        // Reset while waiting for ack.
        cpuRead = 1'b1; cpuAddress = 16'h0777; tagHit = 1'b0; lineState = INVALID;
        step(); cpuRead = 1'b0;
        step(); busGrant = 1'b1;
        step(); reset = 1'b0;
        step(); reset = 1'b1; busGrant = 1'b0;
        #3 chk("rstbus_req", 32'(busRequest), 32'd0);
        chk("rstbus_wait", 32'(cpuWaitRequest), 32'd0);
        chk("rstbus_sw", 32'(stateWrite), 32'd0);
        step();
        #3 chk("rstbus_sw_after", 32'(stateWrite), 32'd0);

        // Simultaneous read and write is a write.
        cpuRead = 1'b1; cpuWrite = 1'b1; cpuAddress = 16'h0200; tagHit = 1'b1;
        lineState = MODIFIED; stateIn = MODIFIED;
        step(); cpuRead = 1'b0; cpuWrite = 1'b0;
        #3 chk("both_write", 32'(write), 32'd1);
        chk("both_read", 32'(read), 32'd0);
        step(); step(); step();

        for (int i = 0; i < 4000; i++) begin
            step();
            reset                 = ($urandom_range(0, 99) != 0);
            cpuRead               = ($urandom_range(0, 3) == 0);
            cpuWrite              = ($urandom_range(0, 3) == 0);
            cpuAddress            = 16'($urandom);
            victimAddress         = 16'($urandom);
            tagHit                = 1'($urandom);
            lineState             = State_t'($urandom_range(0, 2));
            stateIn               = State_t'($urandom_range(0, 2));
            writeBackRequired     = ($urandom_range(0, 3) == 0);
            readExclusiveRequired = ($urandom_range(0, 3) == 0);
            invalidateRequired    = ($urandom_range(0, 3) == 0);
            busGrant              = ($urandom_range(0, 1) == 0);
            busAck                = ($urandom_range(0, 2) == 0);
        end
        step(); quiet();
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameters SHALL be: STATE_TYPE, default cache_states::State_t, line coherence state type; ADDRESS_WIDTH, default 16, address width.
REQ-002 Port clock  in  1  system clock; all logic on rising edge.
REQ-003 Port reset  in  1  synchronous, active-low reset.
REQ-004 CPU ports: cpuRead in 1; cpuWrite in 1; cpuAddress in ADDRESS_WIDTH; cpuWaitRequest out 1, high while a request is being serviced.
REQ-005 Cache ports: tagHit in 1, indexed line tag matches; lineState in STATE_TYPE; victimAddress in ADDRESS_WIDTH; stateWrite out 1, one-cycle line-state write strobe; stateWriteValue out STATE_TYPE.
REQ-006 Protocol ports: read out 1; write out 1; stateOut out STATE_TYPE; writeBackState out STATE_TYPE; stateIn in STATE_TYPE, protocol next state; writeBackRequired in 1; invalidateRequired in 1; readExclusiveRequired in 1.
REQ-007 Bus ports: busRequest out 1; busGrant in 1; busCommand out 2; busAddress out ADDRESS_WIDTH; busAck in 1.

Function
REQ-008 FSM states SHALL be IDLE, LOOKUP, WRITE_BACK, READ_EXCLUSIVE, INVALIDATE, BUS_READ, UPDATE, DONE.
REQ-009 IDLE: on cpuRead|cpuWrite, register op and cpuAddress, set cpuWaitRequest next cycle, go LOOKUP; cpuRead and cpuWrite together SHALL be treated as a write.
REQ-010 read/write SHALL reflect the registered op in all states except IDLE and DONE, and SHALL be 0 in IDLE and DONE.
REQ-011 stateOut SHALL be lineState when tagHit=1, else INVALID; writeBackState SHALL be lineState when tagHit=0, else INVALID.
REQ-012 LOOKUP, one cycle, priority order: writeBackRequired -> WRITE_BACK; readExclusiveRequired -> READ_EXCLUSIVE; invalidateRequired -> INVALIDATE; read miss (stateOut INVALID) -> BUS_READ; otherwise -> UPDATE.
REQ-013 Bus states: busRequest SHALL assert on entry and hold until the busAck cycle; busCommand/busAddress SHALL be valid while busGrant=1; busRequest SHALL drop the cycle after busAck.
REQ-014 busCommand encodings: BUS_READ=0, BUS_READ_EXCLUSIVE=1, BUS_INVALIDATE=2, BUS_WRITE_BACK=3.
REQ-015 busAddress SHALL be victimAddress in WRITE_BACK, registered cpuAddress otherwise.
REQ-016 WRITE_BACK on busAck: pulse stateWrite with INVALID, return to LOOKUP; lookup re-evaluates without a writeback.
REQ-017 READ_EXCLUSIVE, INVALIDATE, BUS_READ on busAck SHALL go to UPDATE.
REQ-018 UPDATE: one-cycle stateWrite with stateWriteValue=stateIn, go DONE.
REQ-019 DONE: cpuWaitRequest=0 for exactly one cycle, go IDLE; a new request is accepted only in IDLE.
REQ-020 Hit latency SHALL be 4 cycles from request edge to cpuWaitRequest low (IDLE, LOOKUP, UPDATE, DONE).
REQ-021 busAck without prior busGrant SHALL be ignored; busGrant deassert before busAck SHALL keep busRequest high.

Reset
REQ-022 reset=0 at an edge SHALL force IDLE in any state; outputs: cpuWaitRequest 0, busRequest 0, busCommand 0, busAddress 0, stateWrite 0, stateWriteValue INVALID, read 0, write 0.
REQ-023 Reset mid-bus-transaction SHALL drop busRequest the next edge; no stateWrite SHALL follow.

Structure
REQ-024 Package cache_states SHALL hold State_t (INVALID, SHARED, MODIFIED); package commands SHALL hold BusCommand_t encodings.
REQ-025 Bus request/grant/ack handshake SHALL be one sub-module, bus_handshake, instantiated once.

Verification
REQ-026 Read hit, lineState SHARED, no protocol flags -> stateWrite SHARED at cycle 3, cpuWaitRequest low at cycle 4.
REQ-027 Read miss, no flags -> busCommand 0, grant after 2 cycles, ack after 3 -> UPDATE writes stateIn=SHARED.
REQ-028 Write miss, victim MODIFIED, writeBackRequired=1 -> BUS_WRITE_BACK at victimAddress 0x1234, stateWrite INVALID, then BUS_READ_EXCLUSIVE at cpuAddress, final MODIFIED.
REQ-029 Write hit SHARED, invalidateRequired=1 -> busCommand 2, then stateWrite MODIFIED.
REQ-030 reset=0 while waiting for busAck -> busRequest 0 next edge, IDLE, no stateWrite.
REQ-031 cpuRead and cpuWrite both high -> write=1, read=0 seen by protocol.
